uart_frame_packer: RTL and testbench
====================================

UART_FRAME_PACKER -- requirements
Module: uart_frame_packer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 100000: idle cycles allowed between bytes inside a frame before the frame is aborted.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port rx_data_i, input, 8 bits: received UART byte.
REQ-006 SHALL have port rx_vld_i, input, 1 bit: one-cycle strobe qualifying rx_data_i; back-to-back strobes are legal.
REQ-007 SHALL have port data_o, output, 64 bits: assembled payload word.
REQ-008 SHALL have port data_vld_o, output, 1 bit: one-cycle strobe qualifying data_o.
REQ-009 SHALL have port addr_init_o, output, 16 bits: load start address.
REQ-010 SHALL have port addr_init_vld_o, output, 1 bit: one-cycle strobe qualifying addr_init_o.
REQ-011 SHALL have port err_o, output, 1 bit: one-cycle strobe on any aborted frame.
REQ-012 SHALL have port word_cnt_o, output, 16 bits: count of data words emitted since the last address frame.

Function
REQ-013 SHALL use FSM states S_IDLE, S_CMD, S_ADDR, S_DATA and S_CSUM, together with a 3-bit byte index.
REQ-014 S_IDLE SHALL discard every byte except SYNC_BYTE; on SYNC_BYTE it SHALL go to S_CMD.
REQ-015 S_CMD SHALL decode the byte as follows:
- 8'h01: go to S_ADDR.
- 8'h02: go to S_DATA.
- Any other value: err_o pulse, then S_IDLE.
REQ-016 S_ADDR SHALL take 2 bytes MSB first.
REQ-017 S_DATA SHALL take 8 bytes MSB first; the first payload byte lands in data_o[63:56].
REQ-018 On acceptance of the final frame byte, the block SHALL register the strobe and return to S_IDLE in the same edge; latency from that rx_vld_i cycle to the strobe is exactly 1 cycle.
REQ-019 A byte arriving on the cycle after a frame ends SHALL be evaluated in S_IDLE; no byte is lost.
REQ-020 data_o and addr_init_o SHALL hold their last value between strobes.
REQ-021 word_cnt_o SHALL clear on each addr_init_vld_o, increment on each data_vld_o, and wrap from 16'hFFFF to 0.
REQ-022 An inter-byte timeout counter SHALL behave as follows:
- Clears on every rx_vld_i.
- Counts only outside S_IDLE.
- Upon reaching TIMEOUT_CYC-1: err_o pulse, S_IDLE, partial frame discarded, no data or address strobe.
REQ-023 data_vld_o, addr_init_vld_o and err_o SHALL be mutually exclusive in any cycle.

Reset
REQ-024 While rst_i is high, the block SHALL hold S_IDLE, clear the byte index and timeout counter, and drive the following outputs to 0: data_o, addr_init_o, word_cnt_o and all strobes.
REQ-025 Reset mid-frame SHALL discard the partial frame without an err_o pulse; a byte presented during reset SHALL be ignored.

Configuration
REQ-026 With UART_PACKER_CHECKSUM_EN defined, each frame SHALL carry one extra byte that is checked in S_CSUM:
- Check value: XOR of the command and payload bytes.
- Match: emit the strobe.
- Mismatch: err_o pulse instead of the strobe.
REQ-027 Without UART_PACKER_CHECKSUM_EN, S_CSUM and the XOR register SHALL be absent, and the strobe SHALL follow the last payload byte.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, the command codes CMD_ADDR=8'h01 and CMD_DATA=8'h02, and the default SYNC_BYTE.
REQ-029 The block SHALL be a single module with no sub-modules; its outputs connect directly to the word and address inputs of the cross-clock ISA buffer on the same clk_i.

Verification
REQ-030 The bench SHALL check an address frame: A5 01 12 34 -> one addr_init_vld_o with addr_init_o=16'h1234, and word_cnt_o=0.
REQ-031 The bench SHALL check a data frame with back-to-back bytes: A5 02 01 23 45 67 89 AB CD EF -> data_vld_o exactly 1 cycle after the last byte, data_o=64'h0123456789ABCDEF, and word_cnt_o=1.
REQ-032 The bench SHALL check junk and a bad command: 00 FF A5 07 -> single err_o pulse and no data or address strobe; a following valid address frame -> decoded normally.
REQ-033 The bench SHALL check timeout with TIMEOUT_CYC=16:
- Stimulus: A5 02 11 22, then 16 silent cycles.
- Required: err_o pulse and no data_vld_o.
- Then a full data frame -> decoded correctly.
REQ-034 With UART_PACKER_CHECKSUM_EN defined, the bench SHALL check checksums:
- A5 01 00 10 11 -> addr_init_o=16'h0010.
- Last byte 12 instead -> err_o pulse and no strobe.
REQ-035 The bench SHALL check reset mid-frame: rst_i asserted after A5 02 AA -> no strobe and no err_o; after release, A5 02 plus 8 bytes -> correct word.

Source files
------------

// File: rtl/uart_frame_packer_pkg.sv
// rtl/uart_frame_packer_pkg.sv - shared FSM states, command codes and default sync byte (S_CSUM exists only with UART_PACKER_CHECKSUM_EN)
package uart_frame_packer_pkg;

    localparam logic [7:0] CMD_ADDR          = 8'h01;
    localparam logic [7:0] CMD_DATA          = 8'h02;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3
`ifdef UART_PACKER_CHECKSUM_EN
        ,
        S_CSUM = 3'd4
`endif
    } state_t;

endpackage

// File: rtl/uart_frame_packer.sv
// rtl/uart_frame_packer.sv - UART byte stream to address/data frame decoder; UART_PACKER_CHECKSUM_EN adds a trailing XOR checksum byte
module uart_frame_packer
    import uart_frame_packer_pkg::*;
#(
    parameter int         TIMEOUT_CYC = 100000,
    parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_vld_i,
    output logic [63:0] data_o,
    output logic        data_vld_o,
    output logic [15:0] addr_init_o,
    output logic        addr_init_vld_o,
    output logic        err_o,
    output logic [15:0] word_cnt_o
);

    localparam int            TW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
`ifdef UART_PACKER_CHECKSUM_EN
    // The checksum byte arrives after the payload, so the whole word must already be held.
    localparam int            SHW      = 64;
`else
    // The final payload byte is taken straight from rx_data_i, so only 7 bytes are held.
    localparam int            SHW      = 56;
`endif

    state_t          state, state_nxt;
    logic [2:0]      idx, idx_nxt;
    logic [TW-1:0]   tmo_cnt;
    logic [SHW-1:0]  shreg;
    logic            tmo_hit;
    logic            set_data, set_addr, set_err;
    logic [63:0]     data_word;
    logic [15:0]     addr_word;
`ifdef UART_PACKER_CHECKSUM_EN
    logic [7:0]      csum;
    logic            is_addr;

    assign data_word = shreg;
    assign addr_word = shreg[15:0];
`else
    assign data_word = {shreg, rx_data_i};
    assign addr_word = {shreg[7:0], rx_data_i};
`endif

    // A byte arriving in the expiry cycle wins over the timeout.
    assign tmo_hit = (state != S_IDLE) && !rx_vld_i && (tmo_cnt == TMO_LAST);

    // Next-state decode and strobe requests for the byte accepted this cycle
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        set_data  = 1'b0;
        set_addr  = 1'b0;
        set_err   = 1'b0;
        if (tmo_hit) begin
            set_err   = 1'b1;
            state_nxt = S_IDLE;
        end else if (rx_vld_i) begin
            case (state)
                S_IDLE: begin
                    if (rx_data_i == SYNC_BYTE) state_nxt = S_CMD;
                end
                S_CMD: begin
                    idx_nxt = 3'd0;
                    if (rx_data_i == CMD_ADDR) begin
                        state_nxt = S_ADDR;
                    end else if (rx_data_i == CMD_DATA) begin
                        state_nxt = S_DATA;
                    end else begin
                        set_err   = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
                S_ADDR: begin
                    idx_nxt = idx + 3'd1;
                    if (idx == 3'd1) begin
                        idx_nxt = 3'd0;
`ifdef UART_PACKER_CHECKSUM_EN
                        state_nxt = S_CSUM;
`else
                        set_addr  = 1'b1;
                        state_nxt = S_IDLE;
`endif
                    end
                end
                S_DATA: begin
                    idx_nxt = idx + 3'd1;
                    if (idx == 3'd7) begin
                        idx_nxt = 3'd0;
`ifdef UART_PACKER_CHECKSUM_EN
                        state_nxt = S_CSUM;
`else
                        set_data  = 1'b1;
                        state_nxt = S_IDLE;
`endif
                    end
                end
`ifdef UART_PACKER_CHECKSUM_EN
                S_CSUM: begin
                    state_nxt = S_IDLE;
                    if (rx_data_i == csum) begin
                        set_addr = is_addr;
                        set_data = !is_addr;
                    end else begin
                        set_err  = 1'b1;
                    end
                end
`endif
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // State register, byte index and inter-byte timeout counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            idx     <= 3'd0;
            tmo_cnt <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (state == S_IDLE || rx_vld_i || tmo_hit) tmo_cnt <= '0;
            else                                        tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Payload shift register, registered strobes, output words and word counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg           <= '0;
            data_o          <= '0;
            addr_init_o     <= '0;
            word_cnt_o      <= '0;
            data_vld_o      <= 1'b0;
            addr_init_vld_o <= 1'b0;
            err_o           <= 1'b0;
        end else begin
            data_vld_o      <= set_data;
            addr_init_vld_o <= set_addr;
            err_o           <= set_err;
            if (rx_vld_i && (state == S_ADDR || state == S_DATA))
                shreg <= {shreg[SHW-9:0], rx_data_i};
            if (set_data) data_o      <= data_word;
            if (set_addr) addr_init_o <= addr_word;
            if (set_addr)      word_cnt_o <= '0;
            else if (set_data) word_cnt_o <= word_cnt_o + 16'd1;
        end
    end

`ifdef UART_PACKER_CHECKSUM_EN
    // Running XOR of command and payload bytes, and which strobe the frame ends in
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            csum    <= 8'd0;
            is_addr <= 1'b0;
        end else if (rx_vld_i) begin
            if (state == S_CMD) begin
                csum    <= rx_data_i;
                is_addr <= (rx_data_i == CMD_ADDR);
            end else if (state == S_ADDR || state == S_DATA) begin
                csum    <= csum ^ rx_data_i;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_frame_packer.sv
// tb/tb_uart_frame_packer.sv - self-checking randomized bench for uart_frame_packer (checksum tests when UART_PACKER_CHECKSUM_EN is defined)
module tb_uart_frame_packer;

    localparam int TMO    = 16;
    localparam int K_DATA = 1;
    localparam int K_ADDR = 2;
    localparam int K_ERR  = 3;

    typedef struct {
        int          kind;
        logic [63:0] val;
        logic [15:0] wc;
        int          cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_vld = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic [63:0] data;
    logic        data_vld;
    logic [15:0] addr;
    logic        addr_vld;
    logic        err;
    logic [15:0] wc;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          ncyc = 0;
    int          last_cyc = 0;
    int          excl_bad = 0;
    logic [15:0] model_wc = 16'd0;
    ev_t         obs_q[$];
    ev_t         exp_q[$];

    uart_frame_packer #(.TIMEOUT_CYC(TMO), .SYNC_BYTE(8'hA5)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .rx_data_i      (rx_data),
        .rx_vld_i       (rx_vld),
        .data_o         (data),
        .data_vld_o     (data_vld),
        .addr_init_o    (addr),
        .addr_init_vld_o(addr_vld),
        .err_o          (err),
        .word_cnt_o     (wc)
    );

    always #5 clk = ~clk;

    // Event monitor sampled on the falling edge
    always @(negedge clk) begin
        ncyc <= ncyc + 1;
        if ($countones({data_vld, addr_vld, err}) > 1) excl_bad <= excl_bad + 1;
        if (data_vld)      obs_q.push_back('{K_DATA, data, wc, ncyc + 1});
        else if (addr_vld) obs_q.push_back('{K_ADDR, {48'd0, addr}, wc, ncyc + 1});
        else if (err)      obs_q.push_back('{K_ERR, 64'd0, wc, ncyc + 1});
    end

    // Reference model: frame-level outcome and word counter rule
    function automatic void expect_ev(input int kind, input logic [63:0] val, input int cyc);
        if (kind == K_ADDR)      model_wc = 16'd0;
        else if (kind == K_DATA) model_wc = model_wc + 16'd1;
        exp_q.push_back('{kind, val, model_wc, cyc});
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_vld  = 1'b1;
        @(posedge clk); #1;
        rx_vld  = 1'b0;
        last_cyc = ncyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [63:0] pl, input int nb, input int gmax);
        logic [7:0] x;
        logic [7:0] b;
        x = cmd;
        send_byte(8'hA5);
        idle(int'($urandom_range(gmax, 0)));
        send_byte(cmd);
        for (int i = 0; i < nb; i++) begin
            idle(int'($urandom_range(gmax, 0)));
            b = pl[8*(nb-1-i) +: 8];
            x = x ^ b;
            send_byte(b);
        end
`ifdef UART_PACKER_CHECKSUM_EN
        idle(int'($urandom_range(gmax, 0)));
        send_byte(x);
`endif
    endtask

    task automatic start_test();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_data = 8'hA5; rx_vld = 1'b1;
        idle(3);
        n_cmp++; if (data !== 64'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data); end
        n_cmp++; if (addr !== 16'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", addr); end
        n_cmp++; if (wc !== 16'd0) begin n_fail++; $display("FAIL reset_wcnt: got %h want 0", wc); end
        n_cmp++; if ({data_vld, addr_vld, err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes: got %b want 000", {data_vld, addr_vld, err});
        end
        rx_vld = 1'b0; rst = 1'b0;
        model_wc = 16'd0;
        start_test();
        send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
        idle(4);
        n_cmp++; if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL reset_byte_ignored: got %0d events want 0", obs_q.size());
        end
    endtask

    task automatic test_addr_frame();
        start_test();
        send_frame(8'h01, 64'h1234, 2, 0);
        expect_ev(K_ADDR, 64'h1234, last_cyc + 1);
        idle(4);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL addr_frame count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].kind != exp_q[i].kind || obs_q[i].val !== exp_q[i].val || obs_q[i].wc !== exp_q[i].wc || obs_q[i].cyc != exp_q[i].cyc) begin
                n_fail++;
                $display("FAIL addr_frame ev%0d: got k=%0d v=%h wc=%h c=%0d want k=%0d v=%h wc=%h c=%0d", i, obs_q[i].kind, obs_q[i].val, obs_q[i].wc, obs_q[i].cyc, exp_q[i].kind, exp_q[i].val, exp_q[i].wc, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_data_frame();
        start_test();
        send_frame(8'h02, 64'h0123456789ABCDEF, 8, 0);
        expect_ev(K_DATA, 64'h0123456789ABCDEF, last_cyc + 1);
        idle(4);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL data_frame count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].kind != exp_q[i].kind || obs_q[i].val !== exp_q[i].val || obs_q[i].wc !== exp_q[i].wc || obs_q[i].cyc != exp_q[i].cyc) begin
                n_fail++;
                $display("FAIL data_frame ev%0d: got k=%0d v=%h wc=%h c=%0d want k=%0d v=%h wc=%h c=%0d", i, obs_q[i].kind, obs_q[i].val, obs_q[i].wc, obs_q[i].cyc, exp_q[i].kind, exp_q[i].val, exp_q[i].wc, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_bad_cmd();
        logic [15:0] a;
        start_test();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA5); send_byte(8'h07);
        expect_ev(K_ERR, 64'd0, last_cyc + 1);
        idle(3);
        a = 16'($urandom);
        send_frame(8'h01, {48'd0, a}, 2, 1);
        expect_ev(K_ADDR, {48'd0, a}, last_cyc + 1);
        idle(4);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL bad_cmd count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].kind != exp_q[i].kind || obs_q[i].val !== exp_q[i].val || obs_q[i].wc !== exp_q[i].wc || obs_q[i].cyc != exp_q[i].cyc) begin
                n_fail++;
                $display("FAIL bad_cmd ev%0d: got k=%0d v=%h wc=%h c=%0d want k=%0d v=%h wc=%h c=%0d", i, obs_q[i].kind, obs_q[i].val, obs_q[i].wc, obs_q[i].cyc, exp_q[i].kind, exp_q[i].val, exp_q[i].wc, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_timeout();
        logic [63:0] w;
        start_test();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
        idle(TMO + 4);
        expect_ev(K_ERR, 64'd0, -1);
        w = {$urandom, $urandom};
        send_frame(8'h02, w, 8, 0);
        expect_ev(K_DATA, w, last_cyc + 1);
        idle(3);
        // Long but legal gaps between bytes must not abort the frame
        w = {$urandom, $urandom};
        send_frame(8'h02, w, 8, TMO - 4);
        expect_ev(K_DATA, w, -1);
        idle(4);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL timeout count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].kind != exp_q[i].kind || obs_q[i].val !== exp_q[i].val || obs_q[i].wc !== exp_q[i].wc || (exp_q[i].cyc >= 0 && obs_q[i].cyc != exp_q[i].cyc)) begin
                n_fail++;
                $display("FAIL timeout ev%0d: got k=%0d v=%h wc=%h c=%0d want k=%0d v=%h wc=%h c=%0d", i, obs_q[i].kind, obs_q[i].val, obs_q[i].wc, obs_q[i].cyc, exp_q[i].kind, exp_q[i].val, exp_q[i].wc, exp_q[i].cyc);
            end
        end
    endtask

`ifdef UART_PACKER_CHECKSUM_EN
    task automatic test_checksum();
        start_test();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h10); send_byte(8'h11);
        expect_ev(K_ADDR, 64'h0010, last_cyc + 1);
        idle(2);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h10); send_byte(8'h12);
        expect_ev(K_ERR, 64'd0, last_cyc + 1);
        idle(4);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL checksum count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].kind != exp_q[i].kind || obs_q[i].val !== exp_q[i].val || obs_q[i].wc !== exp_q[i].wc || obs_q[i].cyc != exp_q[i].cyc) begin
                n_fail++;
                $display("FAIL checksum ev%0d: got k=%0d v=%h wc=%h c=%0d want k=%0d v=%h wc=%h c=%0d", i, obs_q[i].kind, obs_q[i].val, obs_q[i].wc, obs_q[i].cyc, exp_q[i].kind, exp_q[i].val, exp_q[i].wc, exp_q[i].cyc);
            end
        end
    endtask
`endif

    task automatic test_reset_mid_frame();
        logic [63:0] w;
        start_test();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA);
        rst = 1'b1;
        idle(2);
        n_cmp++; if (wc !== 16'd0) begin n_fail++; $display("FAIL midrst_wcnt: got %h want 0", wc); end
        rst = 1'b0;
        model_wc = 16'd0;
        idle(2);
        w = {$urandom, $urandom};
        send_frame(8'h02, w, 8, 0);
        expect_ev(K_DATA, w, last_cyc + 1);
        idle(4);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL midrst count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].kind != exp_q[i].kind || obs_q[i].val !== exp_q[i].val || obs_q[i].wc !== exp_q[i].wc || obs_q[i].cyc != exp_q[i].cyc) begin
                n_fail++;
                $display("FAIL midrst ev%0d: got k=%0d v=%h wc=%h c=%0d want k=%0d v=%h wc=%h c=%0d", i, obs_q[i].kind, obs_q[i].val, obs_q[i].wc, obs_q[i].cyc, exp_q[i].kind, exp_q[i].val, exp_q[i].wc, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] w;
        logic [15:0] a;
        start_test();
        a = 16'($urandom);
        send_frame(8'h01, {48'd0, a}, 2, 0);
        expect_ev(K_ADDR, {48'd0, a}, last_cyc + 1);
        w = {$urandom, $urandom};
        send_frame(8'h02, w, 8, 0);
        expect_ev(K_DATA, w, last_cyc + 1);
        send_byte(8'hA5); send_byte(8'h05);
        expect_ev(K_ERR, 64'd0, last_cyc + 1);
        w = {$urandom, $urandom};
        send_frame(8'h02, w, 8, 0);
        expect_ev(K_DATA, w, last_cyc + 1);
        idle(4);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL b2b count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].kind != exp_q[i].kind || obs_q[i].val !== exp_q[i].val || obs_q[i].wc !== exp_q[i].wc || obs_q[i].cyc != exp_q[i].cyc) begin
                n_fail++;
                $display("FAIL b2b ev%0d: got k=%0d v=%h wc=%h c=%0d want k=%0d v=%h wc=%h c=%0d", i, obs_q[i].kind, obs_q[i].val, obs_q[i].wc, obs_q[i].cyc, exp_q[i].kind, exp_q[i].val, exp_q[i].wc, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] w;
        logic [7:0]  j;
        int          kind;
        int          k;
        start_test();
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(2, 0)) begin
                j = 8'($urandom);
                if (j == 8'hA5) j = 8'h5A;
                send_byte(j);
                idle(int'($urandom_range(2, 0)));
            end
            kind = int'($urandom_range(3, 0));
            w = {$urandom, $urandom};
            if (kind == 0) begin
                send_frame(8'h01, {48'd0, w[15:0]}, 2, 3);
                expect_ev(K_ADDR, {48'd0, w[15:0]}, last_cyc + 1);
            end else if (kind == 1) begin
                send_frame(8'h02, w, 8, 3);
                expect_ev(K_DATA, w, last_cyc + 1);
            end else if (kind == 2) begin
                j = 8'($urandom);
                if (j == 8'h01 || j == 8'h02) j = 8'h7E;
                send_byte(8'hA5);
                send_byte(j);
                expect_ev(K_ERR, 64'd0, last_cyc + 1);
            end else begin
                send_byte(8'hA5);
                k = int'($urandom_range(4, 0));
                for (int i = 0; i < k; i++) send_byte((i == 0) ? 8'h02 : w[7:0]);
                idle(TMO + 4);
                expect_ev(K_ERR, 64'd0, -1);
            end
            idle(int'($urandom_range(3, 0)));
        end
        idle(4);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL random count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].kind != exp_q[i].kind || obs_q[i].val !== exp_q[i].val || obs_q[i].wc !== exp_q[i].wc || (exp_q[i].cyc >= 0 && obs_q[i].cyc != exp_q[i].cyc)) begin
                n_fail++;
                $display("FAIL random ev%0d: got k=%0d v=%h wc=%h c=%0d want k=%0d v=%h wc=%h c=%0d", i, obs_q[i].kind, obs_q[i].val, obs_q[i].wc, obs_q[i].cyc, exp_q[i].kind, exp_q[i].val, exp_q[i].wc, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_exclusive();
        n_cmp++;
        if (excl_bad != 0) begin
            n_fail++; $display("FAIL strobe_exclusive: got %0d overlapping cycles want 0", excl_bad);
        end
    endtask

    initial begin
        test_reset();
        test_addr_frame();
        test_data_frame();
        test_bad_cmd();
        test_timeout();
`ifdef UART_PACKER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
